// File: rtl/fifo_pkg.sv
// Shared width helpers and default sizing constants for the synchronous FIFO family.
package fifo_pkg;

  function automatic int ptrWidth(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int cntWidth(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic bit isPow2(input int value);
    return (value > 0) && ((value & (value - 1)) == 0);
  endfunction

  localparam int DefaultDepth = 16;
  localparam int DefaultPtrW  = ptrWidth(DefaultDepth);
  localparam int DefaultCntW  = cntWidth(DefaultDepth);

endpackage

// File: rtl/fifo_ram.sv
// Storage array for the FIFO: one synchronous write port, one asynchronous read port, no reset.
module fifo_ram
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int PTR_W      = ptrWidth(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [PTR_W-1:0]      waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [PTR_W-1:0]      raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/fifo_sync_flags.sv
// Single-clock FIFO with threshold flags, occupancy, sticky error flags, flush and optional FWFT output.
module fifo_sync_flags
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int AF_LEVEL   = DEPTH - 2,
  parameter int AE_LEVEL   = 2,
  parameter int FWFT       = 0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  input  logic                        clr_err,
  input  logic                        wr_en,
  input  logic [DATA_WIDTH-1:0]       data_in,
  input  logic                        rd_en,
  output logic [DATA_WIDTH-1:0]       data_out,
  output logic                        valid,
  output logic                        full,
  output logic                        empty,
  output logic                        almost_full,
  output logic                        almost_empty,
  output logic [cntWidth(DEPTH)-1:0]  count,
  output logic                        overflow,
  output logic                        underflow
);

  localparam int PTR_W = ptrWidth(DEPTH);
  localparam int CNT_W = cntWidth(DEPTH);

  if (!isPow2(DEPTH) || DEPTH < 2) begin : gBadDepth
    $error("fifo_sync_flags: DEPTH must be a power of 2 and at least 2");
  end
  if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : gBadAf
    $error("fifo_sync_flags: AF_LEVEL must lie in 1..DEPTH");
  end
  if (AE_LEVEL < 0 || AE_LEVEL > DEPTH - 1) begin : gBadAe
    $error("fifo_sync_flags: AE_LEVEL must lie in 0..DEPTH-1");
  end
  if (DATA_WIDTH < 1) begin : gBadWidth
    $error("fifo_sync_flags: DATA_WIDTH must be at least 1");
  end

  logic [PTR_W-1:0]      wPtr_q, wPtr_d;
  logic [PTR_W-1:0]      rPtr_q, rPtr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;
  logic                  rdAcc;
  logic                  wrAcc;
  logic                  memWe;
  logic [DATA_WIDTH-1:0] ramData;

  // All status flags come from the registered count, so none depends on this cycle's requests.
  assign empty        = (count_q == '0);
  assign full         = (count_q == CNT_W'(DEPTH));
  assign almost_full  = (count_q >= CNT_W'(AF_LEVEL));
  assign almost_empty = (count_q <= CNT_W'(AE_LEVEL));
  assign count        = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  assign rdAcc = rd_en & ~empty;
  assign wrAcc = wr_en & (~full | rdAcc);
  assign memWe = wrAcc & ~flush;

  always_comb begin
    wPtr_d  = wPtr_q;
    rPtr_d  = rPtr_q;
    count_d = count_q;
    if (flush) begin
      wPtr_d  = '0;
      rPtr_d  = '0;
      count_d = '0;
    end else begin
      if (wrAcc) wPtr_d = wPtr_q + PTR_W'(1);
      if (rdAcc) rPtr_d = rPtr_q + PTR_W'(1);
      case ({wrAcc, rdAcc})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // A fresh error outranks a simultaneous clear; requests discarded by flush never raise one.
  always_comb begin
    overflow_d  = (overflow_q & ~clr_err) | (~flush & wr_en & ~wrAcc);
    underflow_d = (underflow_q & ~clr_err) | (~flush & rd_en & empty);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wPtr_q      <= '0;
      rPtr_q      <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wPtr_q      <= wPtr_d;
      rPtr_q      <= rPtr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  fifo_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .PTR_W      (PTR_W)
  ) uRam (
    .clk     (clk),
    .we_i    (memWe),
    .waddr_i (wPtr_q),
    .wdata_i (data_in),
    .raddr_i (rPtr_q),
    .rdata_o (ramData)
  );

  if (FWFT == 0) begin : gStdRead
    logic [DATA_WIDTH-1:0] dataOut_q, dataOut_d;
    logic                  valid_q, valid_d;

    always_comb begin
      dataOut_d = dataOut_q;
      valid_d   = 1'b0;
      if (!flush && rdAcc) begin
        dataOut_d = ramData;
        valid_d   = 1'b1;
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        dataOut_q <= '0;
        valid_q   <= 1'b0;
      end else begin
        dataOut_q <= dataOut_d;
        valid_q   <= valid_d;
      end
    end

    assign data_out = dataOut_q;
    assign valid    = valid_q;
  end else begin : gFwftRead
    // The head word is shown directly from the array; zero is forced while empty.
    assign data_out = empty ? '0 : ramData;
    assign valid    = ~empty;
  end

endmodule

// File: tb/tb_fifo_sync_flags.sv
// Randomised and directed check of fifo_sync_flags in both read modes against a queue-based model.
module tb_fifo_sync_flags;

  localparam int DataWidth = 8;
  localparam int Depth     = 16;
  localparam int AfLevel   = 14;
  localparam int AeLevel   = 2;
  localparam int CntW      = 5;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 flush;
  logic                 clrErr;
  logic                 wrEn;
  logic                 rdEn;
  logic [DataWidth-1:0] dataIn;

  logic [DataWidth-1:0] dataOut0, dataOut1;
  logic                 valid0, valid1, full0, full1, empty0, empty1;
  logic                 af0, af1, ae0, ae1, ov0, ov1, uf0, uf1;
  logic [CntW-1:0]      count0, count1;

  logic [DataWidth-1:0] refQ [$];
  bit                   refOv;
  bit                   refUf;
  bit                   refValid;
  logic [DataWidth-1:0] refData;

  int totalChecks = 0;
  int badChecks   = 0;

  always #5 clk = ~clk;

  fifo_sync_flags #(
    .DATA_WIDTH (DataWidth), .DEPTH (Depth), .AF_LEVEL (AfLevel), .AE_LEVEL (AeLevel), .FWFT (0)
  ) uDutStd (
    .clk (clk), .rst (rst), .flush (flush), .clr_err (clrErr),
    .wr_en (wrEn), .data_in (dataIn), .rd_en (rdEn),
    .data_out (dataOut0), .valid (valid0), .full (full0), .empty (empty0),
    .almost_full (af0), .almost_empty (ae0), .count (count0),
    .overflow (ov0), .underflow (uf0)
  );

  fifo_sync_flags #(
    .DATA_WIDTH (DataWidth), .DEPTH (Depth), .AF_LEVEL (AfLevel), .AE_LEVEL (AeLevel), .FWFT (1)
  ) uDutFwft (
    .clk (clk), .rst (rst), .flush (flush), .clr_err (clrErr),
    .wr_en (wrEn), .data_in (dataIn), .rd_en (rdEn),
    .data_out (dataOut1), .valid (valid1), .full (full1), .empty (empty1),
    .almost_full (af1), .almost_empty (ae1), .count (count1),
    .overflow (ov1), .underflow (uf1)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    totalChecks++;
    if (obs !== exp) begin
      badChecks++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic checkAll();
    int n = refQ.size();
    logic [31:0] head = (n > 0) ? 32'(refQ[0]) : 32'h0;
    checkOutput("count_std",  32'(count0), n);
    checkOutput("count_fwft", 32'(count1), n);
    checkOutput("full",       32'({full0, full1}),   {2{n == Depth}});
    checkOutput("empty",      32'({empty0, empty1}), {2{n == 0}});
    checkOutput("almost_full",  32'({af0, af1}), {2{n >= AfLevel}});
    checkOutput("almost_empty", 32'({ae0, ae1}), {2{n <= AeLevel}});
    checkOutput("overflow",   32'({ov0, ov1}), {2{refOv}});
    checkOutput("underflow",  32'({uf0, uf1}), {2{refUf}});
    checkOutput("data_std",   32'(dataOut0), 32'(refData));
    checkOutput("valid_std",  32'(valid0), 32'(refValid));
    checkOutput("data_fwft",  32'(dataOut1), head);
    checkOutput("valid_fwft", 32'(valid1), 32'(n > 0));
  endtask

  task automatic modelReset();
    refQ.delete();
    refOv    = 1'b0;
    refUf    = 1'b0;
    refValid = 1'b0;
    refData  = '0;
  endtask

  // Applies the FIFO rules to the queue for one clock edge using the pre-edge occupancy.
  task automatic modelStep(input bit wr, input logic [DataWidth-1:0] din, input bit rd,
                           input bit fl, input bit ce);
    bit wasEmpty = (refQ.size() == 0);
    bit wasFull  = (refQ.size() == Depth);
    bit rdOk     = rd && !wasEmpty;
    bit wrOk     = wr && (!wasFull || rdOk);
    if (ce) begin
      refOv = 1'b0;
      refUf = 1'b0;
    end
    if (fl) begin
      refQ.delete();
      refValid = 1'b0;
    end else begin
      if (wr && !wrOk) refOv = 1'b1;
      if (rd && wasEmpty) refUf = 1'b1;
      refValid = rdOk;
      if (rdOk) refData = refQ.pop_front();
      if (wrOk) refQ.push_back(din);
    end
  endtask

  task automatic applyStimulus(input bit wr, input logic [DataWidth-1:0] din, input bit rd,
                               input bit fl = 1'b0, input bit ce = 1'b0);
    wrEn   = wr;
    dataIn = din;
    rdEn   = rd;
    flush  = fl;
    clrErr = ce;
    @(posedge clk);
    modelStep(wr, din, rd, fl, ce);
    #1;
    checkAll();
  endtask

  initial begin
    rst    = 1'b1;
    flush  = 1'b0;
    clrErr = 1'b0;
    wrEn   = 1'b0;
    rdEn   = 1'b0;
    dataIn = '0;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    checkAll();
    rst = 1'b0;

    for (int i = 1; i <= Depth; i++) applyStimulus(1'b1, 8'(i), 1'b0);
    applyStimulus(1'b1, 8'hEE, 1'b0);
    for (int i = 0; i <= Depth; i++) applyStimulus(1'b0, 8'h00, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

    for (int i = 0; i < Depth; i++) applyStimulus(1'b1, 8'(8'h80 + i), 1'b0);
    applyStimulus(1'b1, 8'hAA, 1'b1);
    for (int i = 0; i < Depth; i++) applyStimulus(1'b0, 8'h00, 1'b1);

    applyStimulus(1'b1, 8'h55, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);

    applyStimulus(1'b1, 8'h3C, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b1);

    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 8'(8'h20 + i), 1'b0);
    applyStimulus(1'b1, 8'h99, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

    begin
      int wrPct = 50;
      int rdPct = 50;
      for (int cyc = 0; cyc < 1500; cyc++) begin
        if (cyc % 100 == 0) begin
          wrPct = $urandom_range(15, 90);
          rdPct = $urandom_range(15, 90);
        end
        applyStimulus($urandom_range(0, 99) < wrPct, 8'($urandom), $urandom_range(0, 99) < rdPct,
                      $urandom_range(0, 99) < 2, $urandom_range(0, 99) < 5);
      end
    end

    for (int i = 0; i < 7; i++) applyStimulus(1'b1, 8'(8'hC0 + i), i[0]);
    wrEn = 1'b1;
    rdEn = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    modelReset();
    checkAll();
    @(negedge clk);
    #1;
    checkAll();
    rst = 1'b0;
    applyStimulus(1'b1, 8'h42, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b0);

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
